// File: rtl/scratchpad_arbiter.sv
// Two-port round-robin arbiter in front of a single-port 64-bit scratchpad RAM,
// with per-port response registers and a full-array clear sequencer.
module scratchpad_arbiter #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] DEPTH     = 32'h0000_0100,
  localparam int         WAW       = $clog2(DEPTH / 32'd8)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           p0_req_valid,
  output logic           p0_req_ready,
  input  logic           p0_req_write,
  input  logic [31:0]    p0_req_addr,
  input  logic [63:0]    p0_req_wdata,
  input  logic [7:0]     p0_req_mask,
  output logic           p0_rsp_valid,
  input  logic           p0_rsp_ready,
  output logic [63:0]    p0_rsp_rdata,
  output logic           p0_rsp_err,
  input  logic           p1_req_valid,
  output logic           p1_req_ready,
  input  logic           p1_req_write,
  input  logic [31:0]    p1_req_addr,
  input  logic [63:0]    p1_req_wdata,
  input  logic [7:0]     p1_req_mask,
  output logic           p1_rsp_valid,
  input  logic           p1_rsp_ready,
  output logic [63:0]    p1_rsp_rdata,
  output logic           p1_rsp_err,
  output logic           ram_req,
  output logic           ram_write,
  output logic [WAW-1:0] ram_addr,
  output logic [63:0]    ram_wdata,
  output logic [63:0]    ram_wmask,
  input  logic [63:0]    ram_rdata,
  input  logic           clear_start,
  output logic           clear_busy,
  output logic           clear_done
);

  typedef enum logic {ARB = 1'b0, CLEAR = 1'b1} state_e;

  state_e         state_q;
  logic           ptr_q;
  logic           clr_pend_q;
  logic [WAW-1:0] clr_cnt_q;
  logic           clear_done_q;
  logic [1:0]     inflight_q;
  logic [1:0]     infl_rd_q;
  logic [1:0]     infl_err_q;
  logic [1:0]     rsp_valid_q;
  logic [1:0]     rsp_err_q;
  logic [63:0]    rsp_rdata_q [2];

  logic [1:0]     req_valid_s;
  logic [1:0]     rsp_ready_s;
  logic [1:0]     free_s;
  logic [1:0]     elig_s;
  logic [1:0]     gnt_s;
  logic           can_grant_s;
  logic           sel_write_s;
  logic [31:0]    sel_addr_s;
  logic [63:0]    sel_wdata_s;
  logic [7:0]     sel_mask_s;
  logic [32:0]    diff_s;
  logic           in_range_s;

  assign req_valid_s = {p1_req_valid, p0_req_valid};
  assign rsp_ready_s = {p1_rsp_ready, p0_rsp_ready};

  // A freshly requested clear also blocks grants, so no new access slips in ahead of it.
  assign can_grant_s = (state_q == ARB) && !clr_pend_q && !clear_start && !rst;

  // Eligibility and round-robin grant selection
  always_comb begin
    for (int n = 0; n < 2; n++) begin
      free_s[n] = !inflight_q[n] && (!rsp_valid_q[n] || rsp_ready_s[n]);
    end
    elig_s = req_valid_s & free_s & {2{can_grant_s}};
    case (elig_s)
      2'b11:   gnt_s = ptr_q ? 2'b10 : 2'b01;
      default: gnt_s = elig_s;
    endcase
  end

  assign p0_req_ready = gnt_s[0];
  assign p1_req_ready = gnt_s[1];

  assign sel_write_s = gnt_s[1] ? p1_req_write : p0_req_write;
  assign sel_addr_s  = gnt_s[1] ? p1_req_addr  : p0_req_addr;
  assign sel_wdata_s = gnt_s[1] ? p1_req_wdata : p0_req_wdata;
  assign sel_mask_s  = gnt_s[1] ? p1_req_mask  : p0_req_mask;

  // 33-bit subtraction: a borrow means the address lies below the window.
  assign diff_s     = {1'b0, sel_addr_s} - {1'b0, BASE_ADDR};
  assign in_range_s = !diff_s[32] && (diff_s[31:0] < DEPTH);

  // RAM command: clear sweep, granted in-range access, or idle
  always_comb begin
    ram_req   = 1'b0;
    ram_write = 1'b0;
    ram_addr  = '0;
    ram_wdata = 64'd0;
    ram_wmask = 64'd0;
    if (state_q == CLEAR) begin
      ram_req   = 1'b1;
      ram_write = 1'b1;
      ram_addr  = clr_cnt_q;
      ram_wmask = {64{1'b1}};
    end else if ((gnt_s != 2'b00) && in_range_s) begin
      ram_req   = 1'b1;
      ram_write = sel_write_s;
      ram_addr  = diff_s[WAW+2:3];
      ram_wdata = sel_wdata_s;
      for (int i = 0; i < 8; i++) begin
        ram_wmask[8*i +: 8] = {8{sel_mask_s[i]}};
      end
    end else begin
      ram_req = 1'b0;
    end
  end

  // Port tracking, response capture and the ARB/CLEAR state machine
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ARB;
      ptr_q        <= 1'b0;
      clr_pend_q   <= 1'b0;
      clr_cnt_q    <= '0;
      clear_done_q <= 1'b0;
      inflight_q   <= 2'b00;
      infl_rd_q    <= 2'b00;
      infl_err_q   <= 2'b00;
      rsp_valid_q  <= 2'b00;
      rsp_err_q    <= 2'b00;
      for (int n = 0; n < 2; n++) begin
        rsp_rdata_q[n] <= 64'd0;
      end
    end else begin
      inflight_q <= gnt_s;
      if (gnt_s != 2'b00) begin
        ptr_q <= !gnt_s[1];
      end
      for (int n = 0; n < 2; n++) begin
        if (gnt_s[n]) begin
          infl_rd_q[n]  <= !sel_write_s && in_range_s;
          infl_err_q[n] <= !in_range_s;
        end
        if (inflight_q[n]) begin
          rsp_valid_q[n] <= 1'b1;
          rsp_rdata_q[n] <= infl_rd_q[n] ? ram_rdata : 64'd0;
          rsp_err_q[n]   <= infl_err_q[n];
        end else if (rsp_valid_q[n] && rsp_ready_s[n]) begin
          rsp_valid_q[n] <= 1'b0;
        end
      end
      case (state_q)
        ARB: begin
          clear_done_q <= 1'b0;
          if (clear_start || clr_pend_q) begin
            if (inflight_q == 2'b00) begin
              state_q    <= CLEAR;
              clr_pend_q <= 1'b0;
              clr_cnt_q  <= '0;
            end else begin
              clr_pend_q <= 1'b1;
            end
          end
        end
        CLEAR: begin
          if (clr_cnt_q == {WAW{1'b1}}) begin
            state_q      <= ARB;
            clear_done_q <= 1'b1;
          end else begin
            clr_cnt_q    <= clr_cnt_q + WAW'(1'b1);
            clear_done_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= ARB;
          clear_done_q <= 1'b0;
        end
      endcase
    end
  end

  assign p0_rsp_valid = rsp_valid_q[0];
  assign p0_rsp_rdata = rsp_rdata_q[0];
  assign p0_rsp_err   = rsp_err_q[0];
  assign p1_rsp_valid = rsp_valid_q[1];
  assign p1_rsp_rdata = rsp_rdata_q[1];
  assign p1_rsp_err   = rsp_err_q[1];
  assign clear_busy   = (state_q == CLEAR);
  assign clear_done   = clear_done_q;

endmodule

// File: tb/tb_scratchpad_arbiter.sv
// Directed bench for scratchpad_arbiter: window at 0x1000, 256 bytes, with a
// behavioural one-cycle-latency RAM attached.
module tb_scratchpad_arbiter;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [31:0] DEP  = 32'h0000_0100;
  localparam logic [63:0] PAT  = 64'h1122_3344_5566_7788;

  logic        clk, rst;
  logic        p0_req_valid, p0_req_ready, p0_req_write;
  logic [31:0] p0_req_addr;
  logic [63:0] p0_req_wdata;
  logic [7:0]  p0_req_mask;
  logic        p0_rsp_valid, p0_rsp_ready, p0_rsp_err;
  logic [63:0] p0_rsp_rdata;
  logic        p1_req_valid, p1_req_ready, p1_req_write;
  logic [31:0] p1_req_addr;
  logic [63:0] p1_req_wdata;
  logic [7:0]  p1_req_mask;
  logic        p1_rsp_valid, p1_rsp_ready, p1_rsp_err;
  logic [63:0] p1_rsp_rdata;
  logic        ram_req, ram_write;
  logic [4:0]  ram_addr;
  logic [63:0] ram_wdata, ram_wmask, ram_rdata;
  logic        clear_start, clear_busy, clear_done;

  logic [63:0] mem [32];
  int total = 0;
  int bad   = 0;

  scratchpad_arbiter #(.BASE_ADDR(BASE), .DEPTH(DEP)) dut (
    .clk(clk), .rst(rst),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_write(p0_req_write),
    .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata), .p0_req_mask(p0_req_mask),
    .p0_rsp_valid(p0_rsp_valid), .p0_rsp_ready(p0_rsp_ready), .p0_rsp_rdata(p0_rsp_rdata),
    .p0_rsp_err(p0_rsp_err),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_write(p1_req_write),
    .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata), .p1_req_mask(p1_req_mask),
    .p1_rsp_valid(p1_rsp_valid), .p1_rsp_ready(p1_rsp_ready), .p1_rsp_rdata(p1_rsp_rdata),
    .p1_rsp_err(p1_rsp_err),
    .ram_req(ram_req), .ram_write(ram_write), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_wmask(ram_wmask), .ram_rdata(ram_rdata),
    .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural RAM: bit-masked write, read data one cycle after the request
  always @(posedge clk) begin
    if (ram_req) begin
      if (ram_write) mem[ram_addr] <= (mem[ram_addr] & ~ram_wmask) | (ram_wdata & ram_wmask);
      ram_rdata <= mem[ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One uncontended access: grant at N, no response at N+1, response at N+2.
  task automatic access(input logic port, input logic wr, input logic [31:0] addr,
                        input logic [63:0] wd, input logic [7:0] m,
                        input logic [63:0] exp_rd, input logic exp_err, input string tag);
    @(negedge clk);
    if (port == 1'b0) begin
      p0_req_valid = 1'b1; p0_req_write = wr; p0_req_addr = addr; p0_req_wdata = wd; p0_req_mask = m;
    end else begin
      p1_req_valid = 1'b1; p1_req_write = wr; p1_req_addr = addr; p1_req_wdata = wd; p1_req_mask = m;
    end
    #1;
    chk({tag, "_ready"}, port ? p1_req_ready : p0_req_ready, 64'd1);
    chk({tag, "_ramreq"}, ram_req, {63'd0, !exp_err});
    @(negedge clk);
    p0_req_valid = 1'b0;
    p1_req_valid = 1'b0;
    #1;
    chk({tag, "_early"}, port ? p1_rsp_valid : p0_rsp_valid, 64'd0);
    @(negedge clk);
    #1;
    chk({tag, "_valid"}, port ? p1_rsp_valid : p0_rsp_valid, 64'd1);
    chk({tag, "_rdata"}, port ? p1_rsp_rdata : p0_rsp_rdata, exp_rd);
    chk({tag, "_err"}, port ? p1_rsp_err : p0_rsp_err, {63'd0, exp_err});
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = {32'hA5A5_0000, 32'(i)};
    ram_rdata = 64'd0;
    rst = 1'b1; clear_start = 1'b0;
    p0_req_valid = 1'b1; p0_req_write = 1'b0; p0_req_addr = BASE; p0_req_wdata = 64'd0; p0_req_mask = 8'h00;
    p1_req_valid = 1'b0; p1_req_write = 1'b0; p1_req_addr = BASE; p1_req_wdata = 64'd0; p1_req_mask = 8'h00;
    p0_rsp_ready = 1'b1; p1_rsp_ready = 1'b1;

    // Reset state, even with a request present
    @(negedge clk); #1;
    chk("rst_ready0", p0_req_ready, 64'd0);
    chk("rst_ramreq", ram_req, 64'd0);
    chk("rst_rspv0", p0_rsp_valid, 64'd0);
    chk("rst_rspv1", p1_rsp_valid, 64'd0);
    chk("rst_busy", clear_busy, 64'd0);
    chk("rst_done", clear_done, 64'd0);
    p0_req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Write then read back, low address bits ignored
    access(1'b0, 1'b1, BASE + 32'd8, PAT, 8'hFF, 64'd0, 1'b0, "wr8");
    access(1'b0, 1'b0, BASE + 32'd12, 64'd0, 8'h00, PAT, 1'b0, "rd8");

    // Out-of-range above and below the window
    access(1'b1, 1'b0, BASE + DEP, 64'd0, 8'h00, 64'd0, 1'b1, "oor_hi");
    access(1'b1, 1'b1, BASE - 32'd8, 64'hFFFF, 8'hFF, 64'd0, 1'b1, "oor_lo");

    // Both ports request every cycle: strict alternation from port 0
    @(negedge clk);
    p0_req_valid = 1'b1; p0_req_write = 1'b0; p0_req_addr = BASE + 32'd8;
    p1_req_valid = 1'b1; p1_req_write = 1'b0; p1_req_addr = BASE + 32'd16;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      chk($sformatf("alt%0d_r0", i), p0_req_ready, {63'd0, (i % 2 == 0)});
      chk($sformatf("alt%0d_r1", i), p1_req_ready, {63'd0, (i % 2 == 1)});
      chk($sformatf("alt%0d_ram", i), ram_req, 64'd1);
    end
    @(negedge clk);
    p0_req_valid = 1'b0; p1_req_valid = 1'b0;
    repeat (3) @(negedge clk);

    // Port 0 back-pressures its response while port 1 keeps being serviced
    p0_rsp_ready = 1'b0;
    p0_req_valid = 1'b1; p0_req_addr = BASE + 32'd8;
    #1 chk("bp_c0_r0", p0_req_ready, 64'd1);
    @(negedge clk);
    p1_req_valid = 1'b1; p1_req_addr = BASE;
    #1;
    chk("bp_c1_r0", p0_req_ready, 64'd0);
    chk("bp_c1_r1", p1_req_ready, 64'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      chk($sformatf("bp%0d_r0", k), p0_req_ready, 64'd0);
      chk($sformatf("bp%0d_v0", k), p0_rsp_valid, 64'd1);
      chk($sformatf("bp%0d_d0", k), p0_rsp_rdata, PAT);
      chk($sformatf("bp%0d_r1", k), p1_req_ready, {63'd0, (k % 2 == 1)});
    end
    @(negedge clk);
    p0_rsp_ready = 1'b1;
    #1;
    chk("bp_regrant_r0", p0_req_ready, 64'd1);
    chk("bp_regrant_r1", p1_req_ready, 64'd0);
    @(negedge clk);
    p0_req_valid = 1'b0; p1_req_valid = 1'b0;
    repeat (3) @(negedge clk);

    // Partial byte-mask write over a zeroed word
    access(1'b0, 1'b1, BASE + 32'h18, 64'd0, 8'hFF, 64'd0, 1'b0, "zero18");
    access(1'b0, 1'b1, BASE + 32'h18, {64{1'b1}}, 8'h0F, 64'd0, 1'b0, "part18");
    access(1'b0, 1'b0, BASE + 32'h18, 64'd0, 8'h00, 64'h0000_0000_FFFF_FFFF, 1'b0, "rdpart");

    // Clear sweep: 32 ascending writes, requests stalled, restart ignored
    @(negedge clk);
    clear_start = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      clear_start = (i == 5);
      p0_req_valid = 1'b1; p0_req_write = 1'b0; p0_req_addr = BASE + 32'd8;
      #1;
      chk($sformatf("clr%0d_busy", i), clear_busy, 64'd1);
      chk($sformatf("clr%0d_addr", i), ram_addr, 64'(i));
      chk($sformatf("clr%0d_wr", i), {ram_req, ram_write}, 64'd3);
      chk($sformatf("clr%0d_mask", i), ram_wmask, {64{1'b1}});
      chk($sformatf("clr%0d_data", i), ram_wdata, 64'd0);
      chk($sformatf("clr%0d_rdy", i), p0_req_ready, 64'd0);
      chk($sformatf("clr%0d_done", i), clear_done, 64'd0);
    end
    @(negedge clk);
    clear_start = 1'b0; p0_req_valid = 1'b0;
    #1;
    chk("clr_end_busy", clear_busy, 64'd0);
    chk("clr_end_done", clear_done, 64'd1);
    @(negedge clk); #1;
    chk("clr_after_done", clear_done, 64'd0);
    chk("clr_after_busy", clear_busy, 64'd0);
    chk("clr_after_ram", ram_req, 64'd0);
    access(1'b0, 1'b0, BASE + 32'h08, 64'd0, 8'h00, 64'd0, 1'b0, "clr_rd08");
    access(1'b1, 1'b0, BASE + 32'hF8, 64'd0, 8'h00, 64'd0, 1'b0, "clr_rdF8");
    access(1'b0, 1'b0, BASE + 32'h18, 64'd0, 8'h00, 64'd0, 1'b0, "clr_rd18");

    // Reset during an in-flight access discards its response
    @(negedge clk);
    p0_req_valid = 1'b1; p0_req_write = 1'b0; p0_req_addr = BASE;
    #1 chk("mid_rdy", p0_req_ready, 64'd1);
    @(negedge clk);
    p0_req_valid = 1'b0; rst = 1'b1;
    #1 chk("mid_rst_v", p0_rsp_valid, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("mid_rel_v", p0_rsp_valid, 64'd0);
    @(negedge clk); #1;
    chk("mid_rel_v2", p0_rsp_valid, 64'd0);

    // Reset aborts an active clear
    @(negedge clk);
    clear_start = 1'b1;
    @(negedge clk);
    clear_start = 1'b0;
    #1 chk("abort_busy_pre", clear_busy, 64'd1);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("abort_busy", clear_busy, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_ram", ram_req, 64'd0);
    chk("abort_done", clear_done, 64'd0);
    @(negedge clk); #1;
    chk("abort_busy_post", clear_busy, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/scratchpad_arbiter.md
SCRATCHPAD_ARBITER -- requirements
Module: scratchpad_arbiter

Interface
REQ-001 SHALL provide parameter BASE_ADDR, default 32'h00000000, byte base address of the scratchpad window.
REQ-002 SHALL provide parameter DEPTH, default 32'h00000100, scratchpad size in bytes, power of two, at least 16; WAW = log2(DEPTH/8) is the word-address width.
REQ-003 SHALL have port clk  input  1  clock, all logic rising-edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have, for each n in {0,1}, requester ports: pn_req_valid in 1; pn_req_ready out 1; pn_req_write in 1; pn_req_addr in 32 (byte address); pn_req_wdata in 64; pn_req_mask in 8 (byte enables).
REQ-006 SHALL have, for each n in {0,1}, response ports: pn_rsp_valid out 1; pn_rsp_ready in 1; pn_rsp_rdata out 64; pn_rsp_err out 1.
REQ-007 SHALL have RAM ports: ram_req out 1; ram_write out 1; ram_addr out WAW (word index); ram_wdata out 64; ram_wmask out 64 (bit enables); ram_rdata in 64 (valid one cycle after ram_req).
REQ-008 SHALL have clear_start in 1 (single-cycle pulse), clear_busy out 1, clear_done out 1 (single-cycle pulse).

Function
REQ-009 SHALL implement FSM states ARB and CLEAR; ARB->CLEAR when clear_start=1 and no access is in flight, else the request is latched and honoured once in-flight work drains; CLEAR->ARB after the last word is written.
REQ-010 SHALL hold each port in one of three conditions: free, in-flight (granted last cycle), or holding (response register valid); a port is eligible only when its request is valid, its condition is free, and state is ARB with no pending clear.
REQ-011 SHALL grant at most one port per cycle with round-robin priority: the pointer resets to port 0 and, after each grant, points to the port not granted.
REQ-012 SHALL assert pn_req_ready combinationally only in the cycle port n is granted; the transfer occurs when pn_req_valid and pn_req_ready are both 1.
REQ-013 SHALL treat an address as in range iff BASE_ADDR <= addr < BASE_ADDR+DEPTH, with word index (addr-BASE_ADDR)>>3 truncated to WAW bits; low 3 address bits are ignored.
REQ-014 SHALL, for an in-range grant in cycle T, drive ram_req=1, ram_write=pn_req_write, ram_addr=word index, ram_wdata=pn_req_wdata, and ram_wmask bit 8i+j = pn_req_mask[i]; otherwise ram_req=0, ram_write=0.
REQ-015 SHALL, for an out-of-range grant, keep ram_req=0 and produce a response with pn_rsp_err=1 and pn_rsp_rdata=0 at the same latency as an in-range access.
REQ-016 SHALL capture the response at the end of T+1 (ram_rdata for in-range reads, zero for writes and errors) and assert pn_rsp_valid from cycle T+2, holding rdata/err stable until pn_rsp_valid and pn_rsp_ready are both 1.
REQ-017 SHALL allow port n to be re-granted in the same cycle its response handshake completes; grant latency from free to ready is 0 cycles when uncontended.
REQ-018 SHALL sustain one RAM access per cycle when both ports alternate requests and drain responses promptly.
REQ-019 SHALL, in CLEAR, write all-zero data with ram_wmask all ones to word indices 0..DEPTH/8-1, one per cycle, ascending, holding clear_busy=1 throughout; pn_req_ready stays 0.
REQ-020 SHALL pulse clear_done for exactly one cycle, in the cycle after the final clear write, and SHALL ignore clear_start while busy or pending.
REQ-021 SHALL allow a response being held during CLEAR to be drained normally.

Reset
REQ-022 SHALL, while rst=1, force state ARB, pointer to port 0, all ports free, clear pending=0, clear counter=0, and outputs pn_rsp_valid=0, pn_rsp_rdata=0, pn_rsp_err=0, pn_req_ready=0, ram_req=0, ram_write=0, clear_busy=0, clear_done=0.
REQ-023 SHALL discard any in-flight or held response and abort an active clear on reset assertion mid-operation, with no response emitted after reset release.

Verification
REQ-024 SHALL pass: p0 writes 64'h1122334455667788 to BASE_ADDR+8 with mask 8'hFF, then reads the same address -> read response rdata=64'h1122334455667788, err=0, rsp_valid two cycles after grant.
REQ-025 SHALL pass: p0 and p1 both request every cycle with rsp_ready=1 -> grants alternate p0,p1,p0,... and ram_req stays 1 every cycle.
REQ-026 SHALL pass: p1 reads BASE_ADDR+DEPTH -> ram_req=0, rsp_err=1, rdata=0 at grant+2.
REQ-027 SHALL pass: p0 rsp_ready held 0 for 5 cycles with p0_req_valid=1 -> p0 not re-granted, p1 still serviced, p0 response stable.
REQ-028 SHALL pass: partial write mask 8'h0F of 64'hFFFFFFFFFFFFFFFF over a zeroed word -> read returns 64'h00000000FFFFFFFF.
REQ-029 SHALL pass: clear_start with DEPTH=256 -> clear_busy for 32 cycles, writes 0..31, clear_done one cycle later, all subsequent reads return 0.
